// File: rtl/blitz_pixel_sink.sv
// Pixel-plot sink: clips drawer plots, queues them and drives the framebuffer write port; also sweeps full-screen clears.
// Optional macro BLITZ_PIXEL_SINK_TRANSPARENT_KEY_EN drops incoming pixels whose colour equals KEY_COLOUR.
module blitz_pixel_sink #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         SCREEN_W   = 320,
  parameter int         SCREEN_H   = 240,
  parameter logic [2:0] KEY_COLOUR = 3'b111
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [8:0]                    x_in,
  input  logic [7:0]                    y_in,
  input  logic [2:0]                    colour_in,
  input  logic                          writeEn,
  input  logic                          clear_req,
  input  logic [2:0]                    clear_colour,
  input  logic                          fb_ready,
  output logic [8:0]                    fb_x,
  output logic [7:0]                    fb_y,
  output logic [2:0]                    fb_colour,
  output logic                          fb_we,
  output logic                          busy,
  output logic                          clear_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  // fb_we/fb_ready: a write is presented while fb_we=1 and completes on a rising edge
  // where fb_ready=1; until then fb_x/fb_y/fb_colour hold and fb_we is never withdrawn.
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [19:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [8:0]        fb_x_q, fb_x_d;
  logic [7:0]        fb_y_q, fb_y_d;
  logic [2:0]        fb_colour_q, fb_colour_d;
  logic              fb_we_q, fb_we_d;
  logic              clear_done_q, clear_done_d;
  logic              overflow_q, overflow_d;
  logic              clear_pending_q, clear_pending_d;
  logic [2:0]        clear_colour_q, clear_colour_d;
  logic              key_drop, pix_ok, full, push, pop, slot_free;

`ifdef BLITZ_PIXEL_SINK_TRANSPARENT_KEY_EN
  assign key_drop = (colour_in == KEY_COLOUR);
`else
  assign key_drop = (colour_in == KEY_COLOUR) && 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    fb_x_d          = fb_x_q;
    fb_y_d          = fb_y_q;
    fb_colour_d     = fb_colour_q;
    fb_we_d         = fb_we_q;
    clear_done_d    = 1'b0;
    overflow_d      = overflow_q;
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    pop             = 1'b0;

    pix_ok    = writeEn && (x_in < X_LIM) && (y_in < Y_LIM) && !key_drop;
    full      = (count_q == CW'(FIFO_DEPTH));
    push      = pix_ok && !full;
    slot_free = !fb_we_q || fb_ready;

    case (state_q)
      S_IDLE: begin
        if (clear_pending_q && slot_free) begin
          state_d         = S_CLEAR;
          clear_pending_d = 1'b0;
          overflow_d      = 1'b0;
          fb_x_d          = '0;
          fb_y_d          = '0;
          fb_colour_d     = clear_colour_q;
          fb_we_d         = 1'b1;
        end else begin
          if (clear_req) begin
            clear_pending_d = 1'b1;
            clear_colour_d  = clear_colour;
          end
          if (slot_free) begin
            if (count_q != '0) begin
              pop = 1'b1;
              {fb_x_d, fb_y_d, fb_colour_d} = mem_q[rd_ptr_q];
              fb_we_d = 1'b1;
            end else begin
              fb_we_d = 1'b0;
            end
          end
        end
      end
      S_CLEAR: begin
        // The presented coordinate doubles as the sweep position.
        if (fb_we_q && fb_ready) begin
          if (fb_x_q == X_LAST && fb_y_q == Y_LAST) begin
            fb_we_d      = 1'b0;
            clear_done_d = 1'b1;
            state_d      = S_IDLE;
          end else if (fb_x_q == X_LAST) begin
            fb_x_d = '0;
            fb_y_d = fb_y_q + 8'd1;
          end else begin
            fb_x_d = fb_x_q + 9'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_ok && full) overflow_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {x_in, y_in, colour_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      fb_x_q          <= '0;
      fb_y_q          <= '0;
      fb_colour_q     <= '0;
      fb_we_q         <= 1'b0;
      clear_done_q    <= 1'b0;
      overflow_q      <= 1'b0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      fb_x_q          <= fb_x_d;
      fb_y_q          <= fb_y_d;
      fb_colour_q     <= fb_colour_d;
      fb_we_q         <= fb_we_d;
      clear_done_q    <= clear_done_d;
      overflow_q      <= overflow_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
    end
  end

  assign fb_x       = fb_x_q;
  assign fb_y       = fb_y_q;
  assign fb_colour  = fb_colour_q;
  assign fb_we      = fb_we_q;
  assign clear_done = clear_done_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0) || fb_we_q;
endmodule

// File: tb/tb_blitz_pixel_sink.sv
// Bench for blitz_pixel_sink: randomized plots and clears checked against an ordered reference
// stream of accepted pixels plus an arithmetic raster-sweep model.
module tb_blitz_pixel_sink;
  localparam int W     = 320;
  localparam int H     = 240;
  localparam int DEPTH = 16;
  localparam int TOTAL = W * H;
`ifdef BLITZ_PIXEL_SINK_TRANSPARENT_KEY_EN
  localparam bit KEY_ON = 1'b1;
`else
  localparam bit KEY_ON = 1'b0;
`endif

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       writeEn = 1'b0;
  logic       clear_req = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       fb_ready = 1'b1;
  logic [8:0] fb_x;
  logic [7:0] fb_y;
  logic [2:0] fb_colour;
  logic       fb_we, busy, clear_done, overflow;
  logic [4:0] fifo_count;

  always #5 clk = ~clk;

  blitz_pixel_sink #(.FIFO_DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H), .KEY_COLOUR(3'b111)) dut (
    .clk(clk), .resetn(resetn), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .writeEn(writeEn), .clear_req(clear_req), .clear_colour(clear_colour), .fb_ready(fb_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_colour(fb_colour), .fb_we(fb_we), .busy(busy),
    .clear_done(clear_done), .overflow(overflow), .fifo_count(fifo_count)
  );

  // scoreboard state
  int          checks = 0;
  int          failures = 0;
  logic [19:0] exp_q[$];
  bit          in_clear;
  int          sweep_idx;
  logic [2:0]  sweep_col;
  bit          done_due;
  int          done_cnt;
  bit          prev_stall;
  logic [19:0] prev_word, mon_word, mon_exp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit accept(input int x, input int y, input logic [2:0] c);
    return (x < W) && (y < H) && !(KEY_ON && c == 3'b111);
  endfunction

  task automatic reset_model();
    exp_q.delete();
    in_clear   = 1'b0;
    sweep_idx  = 0;
    done_due   = 1'b0;
    prev_stall = 1'b0;
  endtask

  // monitor: every accepted write is either the next raster position or the oldest accepted pixel
  always @(negedge clk) begin
    if (resetn) begin
      mon_word = {fb_x, fb_y, fb_colour};
      if (prev_stall) begin
        chk("hold_we", fb_we, 1);
        chk("hold_pix", mon_word, prev_word);
      end
      if (clear_done || done_due) begin
        chk("clear_done", clear_done, done_due);
        if (done_due) chk("done_we", fb_we, 0);
        if (clear_done) done_cnt++;
        done_due = 1'b0;
      end
      if (fb_we && fb_ready) begin
        if (in_clear) begin
          mon_exp = {9'(sweep_idx % W), 8'(sweep_idx / W), sweep_col};
          chk("sweep", mon_word, mon_exp);
          sweep_idx++;
          if (sweep_idx == TOTAL) begin
            in_clear = 1'b0;
            done_due = 1'b1;
          end
        end else if (exp_q.size() == 0) begin
          chk("spurious_we", fb_we, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("pixel", mon_word, mon_exp);
        end
      end
      prev_stall = fb_we && !fb_ready;
      prev_word  = mon_word;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int x, input int y, input logic [2:0] c, input bit room);
    x_in      = 9'(x);
    y_in      = 8'(y);
    colour_in = c;
    writeEn   = 1'b1;
    if (accept(x, y, c) && room) exp_q.push_back({9'(x), 8'(y), c});
    step();
    writeEn = 1'b0;
  endtask

  task automatic start_clear(input logic [2:0] c);
    clear_req    = 1'b1;
    clear_colour = c;
    in_clear     = 1'b1;
    sweep_idx    = 0;
    sweep_col    = c;
    step();
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready);
    int n = 0;
    while ((busy || exp_q.size() != 0 || in_clear || done_due) && n < budget) begin
      if (rnd_ready) fb_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    fb_ready = 1'b1;
    chk("drain_left", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int  n;
    bit  pushed, reclear;
    reset_model();
    done_cnt = 0;

    // reset values; a plot strobe during reset must be ignored
    writeEn = 1'b1; x_in = 9'd5; y_in = 8'd5; colour_in = 3'b001;
    repeat (3) step();
    writeEn = 1'b0;
    chk("rst_we", fb_we, 0);
    chk("rst_x", fb_x, 0);
    chk("rst_y", fb_y, 0);
    chk("rst_col", fb_colour, 0);
    chk("rst_done", clear_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    step();
    chk("rst_cnt_after", fifo_count, 0);

    // single pixel latency
    fb_ready = 1'b1;
    plot(42, 100, 3'b100, 1);
    @(negedge clk); chk("lat_we0", fb_we, 0);
    @(negedge clk); chk("lat_we1", fb_we, 1);
    chk("lat_x", fb_x, 42); chk("lat_y", fb_y, 100); chk("lat_c", fb_colour, 3'b100);
    @(negedge clk); chk("lat_busy", busy, 0);

    // clipping edges
    plot(320, 10, 3'b001, 1);
    plot(10, 240, 3'b010, 1);
    plot(319, 239, 3'b011, 1);
    wait_idle(50, 0);
    chk("clip_ovf", overflow, 0);

    // randomized bursts with random backpressure, at most 12 plots per burst
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        fb_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) != 0)
          plot($urandom_range(0, 340), $urandom_range(0, 255), 3'($urandom_range(0, 7)), 1);
        else
          step();
      end
      wait_idle(200, 1);
    end
    chk("rand_ovf", overflow, 0);

    // fill under stall: one pixel on the port plus DEPTH queued, the next is dropped
    fb_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) plot(i * 3, i, 3'(i % 7), 1);
    chk("fill_cnt", fifo_count, DEPTH);
    chk("fill_ovf0", overflow, 0);
    plot(200, 200, 3'b001, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_cnt", fifo_count, DEPTH);
    fb_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      @(negedge clk);
      chk("b2b_we", fb_we, 1);
    end
    wait_idle(50, 0);

    // clear interrupted by reset at (100,50)
    start_clear(3'b101);
    n = 0;
    while (sweep_idx < 50 * W + 100 && n < 20000) begin
      step();
      n++;
    end
    chk("mid_x", fb_x, 100);
    chk("mid_y", fb_y, 50);
    chk("mid_we", fb_we, 1);
    chk("mid_ovf", overflow, 0);
    resetn = 1'b0;
    reset_model();
    #1;
    chk("arst_we", fb_we, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", fifo_count, 0);
    step(); step();
    resetn = 1'b1;
    step();

    // full clear: random backpressure window, plots and a re-request during the sweep
    start_clear(3'b010);
    pushed = 1'b0;
    reclear = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 90000) begin
      if (!pushed && sweep_idx >= 1000) begin
        plot(7, 8, 3'b001, 1);
        plot(300, 200, 3'b110, 1);
        plot(0, 0, 3'b101, 1);
        pushed = 1'b1;
      end else begin
        fb_ready = (sweep_idx >= 2000 && sweep_idx < 2100) ? 1'($urandom_range(0, 1)) : 1'b1;
        clear_req = (!reclear && sweep_idx >= 3000);
        if (clear_req) reclear = 1'b1;
        step();
        clear_req = 1'b0;
      end
      n++;
    end
    chk("clear_done_cnt", done_cnt, 1);
    chk("clear_ovf", overflow, 0);
    wait_idle(100, 0);

    // transparent-key colour versus an ordinary colour
    plot(5, 5, 3'b111, 1);
    plot(6, 6, 3'b011, 1);
    wait_idle(50, 0);
    chk("end_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
